// File: rtl/fir_latency_monitor.sv
// fir_latency_monitor
//   Times START_MARK -> END_MARK intervals seen on a firmware-driven marker
//   bus (normally mprj_io[23:16]) over NUM_RUNS runs and keeps per-run,
//   total, min and max latency in clock cycles. Includes timeout, counter
//   saturation and abort (enable low) handling.
//
// Ports
//   wb_clk_i      clock
//   wb_rst_i      asynchronous active-high reset
//   enable        monitor armed; low forces IDLE and aborts an in-flight run
//   clear         synchronous session restart, zeroes results and flags
//   mark_i        marker bus, registered once before any detection
//   busy          high in WAIT_START, MEASURE, RELEASE
//   run_valid     one-cycle pulse when a run completes
//   run_idx       number of completed runs in this session
//   run_latency   latency of the last completed run
//   total_latency saturating sum of run latencies
//   min_latency   minimum run latency (all-ones when no run yet)
//   max_latency   maximum run latency
//   done          sticky, NUM_RUNS runs completed
//   timeout_err   sticky, a run reached TIMEOUT cycles without END
//   overflow      sticky, a counter saturated
//   dbg_state     current FSM state encoding
//
// Handshake: there is no backpressure. run_valid is a single-cycle strobe;
// run_latency, run_idx and the aggregates are already updated in the same
// cycle run_valid is high and then hold until the next completed run.
module fir_latency_monitor #(
  parameter int unsigned          MARK_W     = 8,
  parameter logic [MARK_W-1:0]    START_MARK = 8'hA5,
  parameter logic [MARK_W-1:0]    END_MARK   = 8'h5A,
  parameter int unsigned          NUM_RUNS   = 3,
  parameter int unsigned          CNT_W      = 32,
  parameter int unsigned          TIMEOUT    = 500000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              enable,
  input  logic              clear,
  input  logic [MARK_W-1:0] mark_i,
  output logic              busy,
  output logic              run_valid,
  output logic [7:0]        run_idx,
  output logic [CNT_W-1:0]  run_latency,
  output logic [CNT_W-1:0]  total_latency,
  output logic [CNT_W-1:0]  min_latency,
  output logic [CNT_W-1:0]  max_latency,
  output logic              done,
  output logic              timeout_err,
  output logic              overflow,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_START = 3'd1,
    S_MEASURE    = 3'd2,
    S_RELEASE    = 3'd3,
    S_DONE       = 3'd4,
    S_ERROR      = 3'd5
  } state_t;

  localparam logic [7:0]  RUNS_L    = 8'(NUM_RUNS);
  localparam logic [63:0] TIMEOUT_L = 64'(TIMEOUT);

  state_t             r_state;
  logic [MARK_W-1:0]  r_mark_q;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_run_valid;
  logic [7:0]         r_run_idx;
  logic [CNT_W-1:0]   r_run_latency;
  logic [CNT_W-1:0]   r_total;
  logic [CNT_W-1:0]   r_min;
  logic [CNT_W-1:0]   r_max;
  logic               r_done;
  logic               r_timeout_err;
  logic               r_overflow;

  logic [CNT_W:0]     w_sum;
  logic               w_cnt_at_max;
  logic               w_timeout_hit;
  logic               w_start;
  logic               w_end;

  // One extra bit on the sum exposes the carry used for saturation.
  assign w_sum         = {1'b0, r_total} + {1'b0, r_cnt};
  assign w_cnt_at_max  = (r_cnt == {CNT_W{1'b1}});
  assign w_timeout_hit = (TIMEOUT != 0) && (64'(r_cnt) == TIMEOUT_L);
  assign w_start       = (r_mark_q == START_MARK);
  assign w_end         = (r_mark_q == END_MARK);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state       <= S_IDLE;
      r_mark_q      <= '0;
      r_cnt         <= '0;
      r_run_valid   <= 1'b0;
      r_run_idx     <= '0;
      r_run_latency <= '0;
      r_total       <= '0;
      r_min         <= '1;
      r_max         <= '0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_mark_q    <= mark_i;
      r_run_valid <= 1'b0;
      if (clear) begin
        r_state       <= enable ? S_WAIT_START : S_IDLE;
        r_cnt         <= '0;
        r_run_idx     <= '0;
        r_run_latency <= '0;
        r_total       <= '0;
        r_min         <= '1;
        r_max         <= '0;
        r_done        <= 1'b0;
        r_timeout_err <= 1'b0;
        r_overflow    <= 1'b0;
      end else if (!enable) begin
        // Abort: the partial count is dropped, results are kept.
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_WAIT_START;
          S_WAIT_START: begin
            if (w_start) begin
              r_cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
              r_state <= S_MEASURE;
            end
          end
          S_MEASURE: begin
            // END wins over a timeout in the same cycle; a repeated START
            // is simply ignored here.
            if (w_end) begin
              r_run_latency <= r_cnt;
              r_run_valid   <= 1'b1;
              r_run_idx     <= r_run_idx + 8'd1;
              if (w_sum[CNT_W]) begin
                r_total    <= '1;
                r_overflow <= 1'b1;
              end else begin
                r_total <= w_sum[CNT_W-1:0];
              end
              if (r_cnt < r_min) r_min <= r_cnt;
              if (r_cnt > r_max) r_max <= r_cnt;
              r_state <= S_RELEASE;
            end else if (w_timeout_hit) begin
              r_timeout_err <= 1'b1;
              r_state       <= S_ERROR;
            end else if (w_cnt_at_max) begin
              r_overflow <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_RELEASE: begin
            // A held END counts once: wait for the bus to leave END.
            if (!w_end) begin
              if (r_run_idx == RUNS_L) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_state <= S_WAIT_START;
              end
            end
          end
          S_DONE:  r_state <= S_DONE;
          S_ERROR: r_state <= S_ERROR;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy          = (r_state == S_WAIT_START) || (r_state == S_MEASURE) ||
                         (r_state == S_RELEASE);
  assign run_valid     = r_run_valid;
  assign run_idx       = r_run_idx;
  assign run_latency   = r_run_latency;
  assign total_latency = r_total;
  assign min_latency   = r_min;
  assign max_latency   = r_max;
  assign done          = r_done;
  assign timeout_err   = r_timeout_err;
  assign overflow      = r_overflow;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_fir_latency_monitor.sv
// Directed bench for fir_latency_monitor. Two instances share clock/reset:
//   u_dut_a : CNT_W=32, TIMEOUT=100, NUM_RUNS=3
//   u_dut_b : CNT_W=8,  TIMEOUT=0,   NUM_RUNS=3 (saturation cases)
// run_valid pulses are checked against expected-latency queues.
module tb_fir_latency_monitor;

  localparam logic [7:0] START = 8'hA5;
  localparam logic [7:0] ENDM  = 8'h5A;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_WS = 3'd1, ST_MEAS = 3'd2,
                         ST_DONE = 3'd4, ST_ERR = 3'd5;

  logic clk;
  logic rst;

  logic        a_enable, a_clear;
  logic [7:0]  a_mark;
  logic        a_busy, a_run_valid, a_done, a_timeout_err, a_overflow;
  logic [7:0]  a_run_idx;
  logic [31:0] a_run_latency, a_total, a_min, a_max;
  logic [2:0]  a_state;

  logic        b_enable, b_clear;
  logic [7:0]  b_mark;
  logic        b_busy, b_run_valid, b_done, b_timeout_err, b_overflow;
  logic [7:0]  b_run_idx;
  logic [7:0]  b_run_latency, b_total, b_min, b_max;
  logic [2:0]  b_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] a_exp_q[$];
  logic [31:0] b_exp_q[$];

  fir_latency_monitor #(.NUM_RUNS(3), .CNT_W(32), .TIMEOUT(100)) u_dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .enable(a_enable), .clear(a_clear),
    .mark_i(a_mark), .busy(a_busy), .run_valid(a_run_valid),
    .run_idx(a_run_idx), .run_latency(a_run_latency),
    .total_latency(a_total), .min_latency(a_min), .max_latency(a_max),
    .done(a_done), .timeout_err(a_timeout_err), .overflow(a_overflow),
    .dbg_state(a_state)
  );

  fir_latency_monitor #(.NUM_RUNS(3), .CNT_W(8), .TIMEOUT(0)) u_dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .enable(b_enable), .clear(b_clear),
    .mark_i(b_mark), .busy(b_busy), .run_valid(b_run_valid),
    .run_idx(b_run_idx), .run_latency(b_run_latency),
    .total_latency(b_total), .min_latency(b_min), .max_latency(b_max),
    .done(b_done), .timeout_err(b_timeout_err), .overflow(b_overflow),
    .dbg_state(b_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_mark(input bit sel_b, input logic [7:0] v);
    if (sel_b) b_mark = v;
    else       a_mark = v;
  endtask

  // START, then END k cycles later, then idle long enough to re-arm.
  task automatic run(input bit sel_b, input int k);
    set_mark(sel_b, START); tick(1);
    set_mark(sel_b, 8'h00);
    if (k > 1) tick(k - 1);
    set_mark(sel_b, ENDM); tick(1);
    set_mark(sel_b, 8'h00); tick(3);
  endtask

  task automatic pulse_clear_a();
    a_clear = 1'b1; tick(1); a_clear = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (a_run_valid) begin
      if (a_exp_q.size() == 0) check("a_spurious_run_valid", 32'(a_run_valid), 32'd0);
      else                     check("a_run_latency", a_run_latency, a_exp_q.pop_front());
    end
    if (b_run_valid) begin
      if (b_exp_q.size() == 0) check("b_spurious_run_valid", 32'(b_run_valid), 32'd0);
      else                     check("b_run_latency", 32'(b_run_latency), b_exp_q.pop_front());
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0;
    a_enable = 1'b0; a_clear = 1'b0; a_mark = 8'h00;
    b_enable = 1'b0; b_clear = 1'b0; b_mark = 8'h00;
    #1 rst = 1'b1;
    tick(2);

    // reset values
    check("rst_busy",    32'(a_busy), 0);
    check("rst_valid",   32'(a_run_valid), 0);
    check("rst_idx",     32'(a_run_idx), 0);
    check("rst_lat",     a_run_latency, 0);
    check("rst_total",   a_total, 0);
    check("rst_min",     a_min, 32'hFFFF_FFFF);
    check("rst_max",     a_max, 0);
    check("rst_done",    32'(a_done), 0);
    check("rst_tmo",     32'(a_timeout_err), 0);
    check("rst_ovf",     32'(a_overflow), 0);
    check("rst_state",   32'(a_state), 32'(ST_IDLE));
    check("rst_b_min",   32'(b_min), 32'h0000_00FF);

    rst = 1'b0;
    a_enable = 1'b1; b_enable = 1'b1;
    tick(2);
    check("arm_state", 32'(a_state), 32'(ST_WS));
    check("arm_busy",  32'(a_busy), 1);

    // three runs: 10, 20, 5
    a_exp_q.push_back(10); a_exp_q.push_back(20); a_exp_q.push_back(5);
    run(0, 10);
    run(0, 20);
    check("t1_idx_mid",  32'(a_run_idx), 2);
    check("t1_done_mid", 32'(a_done), 0);
    run(0, 5);
    check("t1_total", a_total, 35);
    check("t1_min",   a_min, 5);
    check("t1_max",   a_max, 20);
    check("t1_idx",   32'(a_run_idx), 3);
    check("t1_done",  32'(a_done), 1);
    check("t1_state", 32'(a_state), 32'(ST_DONE));
    check("t1_busy",  32'(a_busy), 0);
    check("t1_q",     32'(a_exp_q.size()), 0);

    // END held 50 cycles, START two cycles after release
    pulse_clear_a();
    check("t2_clr_idx",  32'(a_run_idx), 0);
    check("t2_clr_done", 32'(a_done), 0);
    check("t2_clr_min",  a_min, 32'hFFFF_FFFF);
    check("t2_clr_st",   32'(a_state), 32'(ST_WS));
    a_exp_q.push_back(8); a_exp_q.push_back(6);
    a_mark = START; tick(1);
    a_mark = 8'h00; tick(7);
    a_mark = ENDM;  tick(50);
    a_mark = 8'h00; tick(2);
    run(0, 6);
    check("t2_idx",   32'(a_run_idx), 2);
    check("t2_total", a_total, 14);
    check("t2_q",     32'(a_exp_q.size()), 0);
    check("t2_state", 32'(a_state), 32'(ST_WS));

    // timeout after one good run of 4
    pulse_clear_a();
    a_exp_q.push_back(4);
    run(0, 4);
    a_mark = START; tick(1);
    a_mark = 8'h00; tick(100);
    check("t3_tmo_before", 32'(a_timeout_err), 0);
    check("t3_st_before",  32'(a_state), 32'(ST_MEAS));
    tick(1);
    check("t3_tmo",   32'(a_timeout_err), 1);
    check("t3_state", 32'(a_state), 32'(ST_ERR));
    check("t3_idx",   32'(a_run_idx), 1);
    check("t3_lat",   a_run_latency, 4);
    check("t3_busy",  32'(a_busy), 0);
    pulse_clear_a();
    check("t3_clr_tmo", 32'(a_timeout_err), 0);
    check("t3_clr_lat", a_run_latency, 0);
    check("t3_clr_min", a_min, 32'hFFFF_FFFF);
    check("t3_clr_st",  32'(a_state), 32'(ST_WS));

    // enable dropped mid-run
    a_exp_q.push_back(7);
    run(0, 7);
    a_mark = START; tick(1);
    a_mark = 8'h00; tick(3);
    a_enable = 1'b0; tick(3);
    check("t5_state", 32'(a_state), 32'(ST_IDLE));
    check("t5_idx",   32'(a_run_idx), 1);
    check("t5_lat",   a_run_latency, 7);
    check("t5_min",   a_min, 7);
    check("t5_max",   a_max, 7);
    check("t5_total", a_total, 7);
    a_enable = 1'b1; tick(2);
    a_exp_q.push_back(4);
    run(0, 4);
    check("t5_min2",   a_min, 4);
    check("t5_total2", a_total, 11);
    check("t5_max2",   a_max, 7);
    check("t5_idx2",   32'(a_run_idx), 2);
    check("t5_q",      32'(a_exp_q.size()), 0);

    // 8-bit counters, no timeout: 300-cycle run saturates
    check("t4_ovf_before", 32'(b_overflow), 0);
    b_exp_q.push_back(255);
    run(1, 300);
    check("t4_lat",   32'(b_run_latency), 255);
    check("t4_ovf",   32'(b_overflow), 1);
    check("t4_total", 32'(b_total), 255);
    b_exp_q.push_back(10);
    run(1, 10);
    check("t4_total2", 32'(b_total), 255);
    check("t4_min2",   32'(b_min), 10);
    check("t4_max2",   32'(b_max), 255);
    check("t4_idx2",   32'(b_run_idx), 2);
    check("t4_q",      32'(b_exp_q.size()), 0);

    // asynchronous reset in the middle of MEASURE
    a_mark = START; tick(1);
    a_mark = 8'h00; tick(4);
    check("t6_pre_state", 32'(a_state), 32'(ST_MEAS));
    #3 rst = 1'b1;
    #1;
    check("t6_busy",  32'(a_busy), 0);
    check("t6_idx",   32'(a_run_idx), 0);
    check("t6_lat",   a_run_latency, 0);
    check("t6_total", a_total, 0);
    check("t6_min",   a_min, 32'hFFFF_FFFF);
    check("t6_max",   a_max, 0);
    check("t6_state", 32'(a_state), 32'(ST_IDLE));
    check("t6_b_min", 32'(b_min), 32'h0000_00FF);
    check("t6_b_ovf", 32'(b_overflow), 0);
    tick(2);
    check("t6_valid", 32'(a_run_valid), 0);
    check("t6_q",     32'(a_exp_q.size()), 0);
    rst = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
